// File: rtl/mem_dump_reader_pkg.sv
// mem_dump_reader_pkg
//   Shared definitions for the memory dump reader: FSM state encoding and
//   default sizing of the memory window it walks.
package mem_dump_reader_pkg;

   localparam int NB_DATA_DEF    = 8;
   localparam int NB_ADDRESS_DEF = 3;
   localparam int N_ADDRESS_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Reader-side master for the sync-write / async-read data memory. On a
//   start request it walks a window of words and streams them out over a
//   valid/ready handshake, one word per transfer (best case 1 word / 2 cycles).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for i_start; base/count sampled here
//   READ  | o_r_en=1, i_r_data captured into o_data at the edge
//   SEND  | o_valid=1, o_data held until o_valid & i_ready
//   DONE  | o_done pulse for one cycle, then back to IDLE
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_start, i_base_addr,   dump request and its window (sampled in IDLE)
//   i_count
//   i_abort                 synchronous cancel while in READ/SEND
//   o_r_addr, o_r_en,       memory read port (data combinational)
//   i_r_data
//   o_data, o_valid,        output stream
//   i_ready
//   o_busy                  high in every state except IDLE
//   o_done                  one-cycle pulse when a dump completes
module mem_dump_reader
   import mem_dump_reader_pkg::*;
#(
   parameter int NB_DATA    = NB_DATA_DEF,
   parameter int NB_ADDRESS = NB_ADDRESS_DEF,
   parameter int N_ADDRESS  = N_ADDRESS_DEF,
   localparam int NB_COUNT  = NB_ADDRESS + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [NB_ADDRESS-1:0] i_base_addr,
   input  logic [NB_COUNT-1:0]   i_count,
   input  logic                  i_abort,
   output logic [NB_ADDRESS-1:0] o_r_addr,
   output logic                  o_r_en,
   input  logic [NB_DATA-1:0]    i_r_data,
   output logic [NB_DATA-1:0]    o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [NB_COUNT-1:0]   N_CNT     = NB_COUNT'(N_ADDRESS);
   localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);

   state_t                state;
   logic [NB_ADDRESS-1:0] addr_q;
   logic [NB_COUNT-1:0]   remaining_q;

   logic                  req_empty;
   logic [NB_COUNT-1:0]   eff_count;
   logic [NB_ADDRESS-1:0] next_addr;

   // Window is empty if nothing asked for or the base lies outside memory.
   assign req_empty = (i_count == '0) || ({1'b0, i_base_addr} >= N_CNT);
   assign eff_count = (i_count > N_CNT) ? N_CNT : i_count;
   // Wrap at N_ADDRESS, which need not be a power of two.
   assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

   assign o_r_addr = addr_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_r_en      <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  o_busy <= 1'b1;
                  if (req_empty) begin
                     state  <= ST_DONE;
                     o_done <= 1'b1;
                  end else begin
                     state       <= ST_READ;
                     addr_q      <= i_base_addr;
                     remaining_q <= eff_count;
                     o_r_en      <= 1'b1;
                  end
               end
            end

            ST_READ: begin
               o_r_en <= 1'b0;
               if (i_abort) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  state   <= ST_SEND;
                  o_data  <= i_r_data;
                  o_valid <= 1'b1;
               end
            end

            ST_SEND: begin
               // Abort wins over a transfer in the same cycle.
               if (i_abort) begin
                  state   <= ST_IDLE;
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
               end else if (i_ready) begin
                  o_valid <= 1'b0;
                  if (remaining_q == NB_COUNT'(1)) begin
                     state  <= ST_DONE;
                     o_done <= 1'b1;
                  end else begin
                     state       <= ST_READ;
                     remaining_q <= remaining_q - 1'b1;
                     addr_q      <= next_addr;
                     o_r_en      <= 1'b1;
                  end
               end
            end

            ST_DONE: begin
               state  <= ST_IDLE;
               o_done <= 1'b0;
               o_busy <= 1'b0;
            end

            default: begin
               state   <= ST_IDLE;
               o_valid <= 1'b0;
               o_r_en  <= 1'b0;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
